// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types and defaults for the two-requester Ethernet TX arbiter.
package eth_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    localparam int DEFAULT_MAX_FRAME_BYTES = 1536;
    localparam int BYTE_CNT_W              = 16;

    // On a tie the requester that was not served last wins.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last_served);
        if (v0 && v1) begin
            return ~last_served;
        end
        return v1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice with registered tready and tvalid.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  skid_last_q, skid_last_d;
    logic                  ready_q, ready_d;
    logic                  in_fire;

    assign in_fire = s_tvalid && ready_q;

    // The skid entry only fills when a beat arrives while the output is stalled.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        if (!out_valid_q || m_tready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = s_tdata;
                    out_last_d = s_tlast;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_tdata;
            skid_last_d  = s_tlast;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            ready_q      <= ready_d;
        end
    end

    assign s_tready = ready_q;
    assign m_tvalid = out_valid_q;
    assign m_tdata  = out_data_q;
    assign m_tlast  = out_last_q;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin merge of two AXI-Stream requesters onto the MAC TX
// input, with truncation of over-long frames and per-requester frame counters.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [15:0]           frame_count0,
    output logic [15:0]           frame_count1,
    output logic                  truncated
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE_IDX = BYTE_CNT_W'(MAX_FRAME_BYTES - 1);

    arb_state_e            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_served_q, last_served_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [15:0]           frame_count0_q, frame_count0_d;
    logic [15:0]           frame_count1_q, frame_count1_d;
    logic                  truncated_q, truncated_d;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  at_limit;
    logic                  buf_valid;
    logic                  buf_ready;
    logic                  buf_last;
    logic                  accept;
    logic                  in_pass;
    logic                  in_drain;

    assign sel_data  = grant_q ? s1_axis_tdata  : s0_axis_tdata;
    assign sel_valid = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last  = grant_q ? s1_axis_tlast  : s0_axis_tlast;
    assign at_limit  = (byte_cnt_q == LAST_BYTE_IDX);
    assign in_pass   = (state_q == ST_PASS);
    assign in_drain  = (state_q == ST_DRAIN);

    assign buf_valid = in_pass && sel_valid;
    assign buf_last  = sel_last || at_limit;
    assign accept    = buf_valid && buf_ready;

    // Draining ignores the output buffer: discarded beats never reach it.
    assign s0_axis_tready = !grant_q && ((in_pass && buf_ready) || in_drain);
    assign s1_axis_tready =  grant_q && ((in_pass && buf_ready) || in_drain);

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_served_d  = last_served_q;
        byte_cnt_d     = byte_cnt_q;
        frame_count0_d = frame_count0_q;
        frame_count1_d = frame_count1_q;
        truncated_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    grant_d = pick_grant(s0_axis_tvalid, s1_axis_tvalid, last_served_q);
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (sel_last) begin
                        last_served_d = grant_q;
                        byte_cnt_d    = '0;
                        state_d       = ST_IDLE;
                        if (grant_q) begin
                            frame_count1_d = frame_count1_q + 16'd1;
                        end else begin
                            frame_count0_d = frame_count0_q + 16'd1;
                        end
                    end else if (at_limit) begin
                        truncated_d = 1'b1;
                        byte_cnt_d  = '0;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (sel_valid && sel_last) begin
                    last_served_d = grant_q;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= 1'b0;
            last_served_q  <= 1'b1;
            byte_cnt_q     <= '0;
            frame_count0_q <= '0;
            frame_count1_q <= '0;
            truncated_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_served_q  <= last_served_d;
            byte_cnt_q     <= byte_cnt_d;
            frame_count0_q <= frame_count0_d;
            frame_count1_q <= frame_count1_d;
            truncated_q    <= truncated_d;
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clock    (clock),
        .reset    (reset),
        .s_tdata  (sel_data),
        .s_tvalid (buf_valid),
        .s_tready (buf_ready),
        .s_tlast  (buf_last),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready),
        .m_tlast  (m_axis_tlast)
    );

    assign frame_count0 = frame_count0_q;
    assign frame_count1 = frame_count1_q;
    assign truncated    = truncated_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter: single frames, round-robin
// ties, truncation, output back-pressure and mid-frame reset.
module tb_eth_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  s0_tdata, s1_tdata, m_tdata;
    logic        s0_tvalid, s0_tready, s0_tlast;
    logic        s1_tvalid, s1_tready, s1_tlast;
    logic        m_tvalid, m_tready, m_tlast;
    logic [15:0] frame_count0, frame_count1;
    logic        truncated;

    eth_tx_arbiter #(
        .DATA_WIDTH      (8),
        .MAX_FRAME_BYTES (1536)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tready (s0_tready),
        .s0_axis_tlast  (s0_tlast),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tready (s1_tready),
        .s1_axis_tlast  (s1_tlast),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .frame_count0   (frame_count0),
        .frame_count1   (frame_count1),
        .truncated      (truncated)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] m_q[$];
    int         m_cyc[$];
    logic [8:0] exp_q[$];
    int         trunc_cnt = 0;
    int         stall_err = 0;
    int         stall_cnt = 0;
    logic       stalled_prev = 1'b0;
    logic [8:0] held = '0;
    logic       abort = 1'b0;
    logic       rand_stop = 1'b0;

    // Output monitor: records every handshake and checks hold-while-stalled.
    always @(negedge clock) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev && (!m_tvalid || {m_tlast, m_tdata} != held)) stall_err++;
            stalled_prev = m_tvalid && !m_tready;
            if (stalled_prev) stall_cnt++;
            held = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                m_q.push_back({m_tlast, m_tdata});
                m_cyc.push_back(cyc);
            end
            if (truncated) trunc_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] gen_byte(input int port, input int frame, input int idx, input int mode);
        case (mode)
            0:       return {port[0], frame[2:0], idx[3:0]};
            1:       return idx[7:0];
            default: return 8'(idx * 7 + 3);
        endcase
    endfunction

    task automatic clear_monitor();
        m_q.delete();
        m_cyc.delete();
        exp_q.delete();
        trunc_cnt = 0;
        stall_err = 0;
        stall_cnt = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        abort     = 1'b0;
        m_tready  = 1'b1;
        s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
        s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        clear_monitor();
    endtask

    task automatic drive(input int port, input logic [7:0] data, input logic last, input logic valid);
        if (port == 0) begin
            s0_tdata = data; s0_tlast = last; s0_tvalid = valid;
        end else begin
            s1_tdata = data; s1_tlast = last; s1_tvalid = valid;
        end
    endtask

    // Sends back-to-back frames, keeping tvalid high across frame boundaries.
    task automatic applyStimulus(input int port, input int nframes, input int len, input int mode);
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < len; i++) begin
                int   waited = 0;
                logic got    = 1'b0;
                drive(port, gen_byte(port, f, i, mode), (i == len - 1), 1'b1);
                while (!got) begin
                    @(negedge clock);
                    if (abort) begin
                        drive(port, 8'h00, 1'b0, 1'b0);
                        return;
                    end
                    got = (port == 0) ? s0_tready : s1_tready;
                    waited++;
                    if (!got && waited > 500) begin
                        checkOutput("accept_timeout", waited, 0);
                        drive(port, 8'h00, 1'b0, 1'b0);
                        return;
                    end
                end
                @(posedge clock);
                #1;
            end
        end
        drive(port, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_frame(input int port, input int frame, input int len, input int mode, input int limit);
        int n = (limit > 0 && len > limit) ? limit : len;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), gen_byte(port, frame, i, mode)});
        end
    endtask

    task automatic wait_beats(input string tag, input int n);
        int w = 0;
        while (m_q.size() < n && w < 5000) begin
            @(negedge clock);
            w++;
        end
        if (m_q.size() < n) checkOutput(tag, m_q.size(), n);
        repeat (5) @(negedge clock);
    endtask

    task automatic compare_seq(input string tag);
        int mism = 0;
        int n    = (m_q.size() < exp_q.size()) ? m_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (m_q[i] != exp_q[i]) mism++;
        end
        checkOutput({tag, "_len"}, m_q.size(), exp_q.size());
        checkOutput({tag, "_data_errs"}, mism, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int tl;

        // Single 64-byte frame from s0; checks reset values, latency and contiguity.
        do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rst_m_tvalid", m_tvalid, 0);
        checkOutput("rst_s0_tready", s0_tready, 0);
        checkOutput("rst_s1_tready", s1_tready, 0);
        checkOutput("rst_fc0", frame_count0, 0);
        checkOutput("rst_fc1", frame_count1, 0);
        checkOutput("rst_truncated", truncated, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        clear_monitor();
        start = cyc;
        expect_frame(0, 0, 64, 1, 0);
        applyStimulus(0, 1, 64, 1);
        wait_beats("t1_timeout", 64);
        compare_seq("t1");
        checkOutput("t1_latency", (m_cyc.size() > 0) ? m_cyc[0] - start : -1, 2);
        checkOutput("t1_contig", (m_cyc.size() >= 64) ? m_cyc[63] - m_cyc[0] : -1, 63);
        checkOutput("t1_fc0", frame_count0, 1);
        checkOutput("t1_trunc", trunc_cnt, 0);

        // Simultaneous requesters alternate whole frames, s0 first.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            expect_frame(0, f, 10, 0, 0);
            expect_frame(1, f, 10, 0, 0);
        end
        fork
            applyStimulus(0, 3, 10, 0);
            applyStimulus(1, 3, 10, 0);
        join
        wait_beats("t2_timeout", 60);
        compare_seq("t2");
        checkOutput("t2_fc0", frame_count0, 3);
        checkOutput("t2_fc1", frame_count1, 3);

        // Over-long s1 frame is cut at 1536, then a short s0 frame passes.
        do_reset();
        expect_frame(1, 0, 2000, 1, 1536);
        expect_frame(0, 0, 4, 1, 0);
        applyStimulus(1, 1, 2000, 1);
        applyStimulus(0, 1, 4, 1);
        wait_beats("t3_timeout", 1540);
        compare_seq("t3");
        checkOutput("t3_trunc_pulses", trunc_cnt, 1);
        checkOutput("t3_fc1", frame_count1, 0);
        checkOutput("t3_fc0", frame_count0, 1);

        // Random output back-pressure during a 100-byte frame.
        do_reset();
        expect_frame(0, 0, 100, 2, 0);
        rand_stop = 1'b0;
        fork
            begin
                applyStimulus(0, 1, 100, 2);
                wait_beats("t4_timeout", 100);
                rand_stop = 1'b1;
            end
            begin
                while (!rand_stop) begin
                    @(posedge clock);
                    #1 m_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_tready = 1'b1;
        repeat (5) @(negedge clock);
        compare_seq("t4");
        checkOutput("t4_stall_hold_errs", stall_err, 0);
        checkOutput("t4_saw_stall", (stall_cnt > 0) ? 1 : 0, 1);
        checkOutput("t4_fc0", frame_count0, 1);

        // Reset around byte 30 of a 60-byte frame, then an s1-only frame.
        do_reset();
        fork
            applyStimulus(0, 1, 60, 1);
            begin
                int w = 0;
                while (m_q.size() < 30 && w < 500) begin
                    @(negedge clock);
                    w++;
                end
                @(posedge clock);
                #1;
                reset = 1'b1;
                abort = 1'b1;
                @(posedge clock);
                @(negedge clock);
                checkOutput("t5_m_tvalid", m_tvalid, 0);
                checkOutput("t5_m_tdata", m_tdata, 0);
                checkOutput("t5_m_tlast", m_tlast, 0);
                checkOutput("t5_s0_tready", s0_tready, 0);
                checkOutput("t5_s1_tready", s1_tready, 0);
                checkOutput("t5_fc0", frame_count0, 0);
                checkOutput("t5_truncated", truncated, 0);
            end
        join
        tl = 0;
        foreach (m_q[i]) if (m_q[i][8]) tl++;
        checkOutput("t5_partial_beats", (m_q.size() >= 30) ? 1 : 0, 1);
        checkOutput("t5_partial_tlast", tl, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        abort = 1'b0;
        clear_monitor();
        expect_frame(1, 0, 8, 2, 0);
        applyStimulus(1, 1, 8, 2);
        wait_beats("t5_timeout", 8);
        compare_seq("t5");
        checkOutput("t5_fc1", frame_count1, 1);
        checkOutput("t5_fc0_after", frame_count0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
